// File: rtl/our_axi_slave_param.sv
// AXI4 slave that bridges one burst at a time onto a single-port synchronous
// memory whose read data returns one cycle after the request.
module our_axi_slave_param #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 40,
   parameter int ID_W   = 8,
   parameter int MEM_AW = 21
) (
   input  logic                pll_core_cpuclk,
   input  logic                pad_cpu_rst_b,
   // AW
   input  logic [ID_W-1:0]     awid_s0,
   input  logic [ADDR_W-1:0]   awaddr_s0,
   input  logic [7:0]          awlen_s0,
   input  logic [2:0]          awsize_s0,
   input  logic [1:0]          awburst_s0,
   input  logic [3:0]          awcache_s0,
   input  logic [2:0]          awprot_s0,
   input  logic                awvalid_s0,
   output logic                awready_s0,
   // W
   input  logic [DATA_W-1:0]   wdata_s0,
   input  logic [DATA_W/8-1:0] wstrb_s0,
   input  logic                wlast_s0,
   input  logic                wvalid_s0,
   output logic                wready_s0,
   // B
   output logic [ID_W-1:0]     bid_s0,
   output logic [1:0]          bresp_s0,
   output logic                bvalid_s0,
   input  logic                bready_s0,
   // AR
   input  logic [ID_W-1:0]     arid_s0,
   input  logic [ADDR_W-1:0]   araddr_s0,
   input  logic [7:0]          arlen_s0,
   input  logic [2:0]          arsize_s0,
   input  logic [1:0]          arburst_s0,
   input  logic [3:0]          arcache_s0,
   input  logic [2:0]          arprot_s0,
   input  logic                arvalid_s0,
   output logic                arready_s0,
   // R
   output logic [ID_W-1:0]     rid_s0,
   output logic [DATA_W-1:0]   rdata_s0,
   output logic [1:0]          rresp_s0,
   output logic                rlast_s0,
   output logic                rvalid_s0,
   input  logic                rready_s0,
   // memory
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [MEM_AW-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_strb_o,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   MEM_BYTES = {{ADDR_W{1'b0}}, 1'b1} << (MEM_AW + LSB);
   localparam logic [2:0] MAX_SIZE    = 3'(LSB);
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, WRITE, WRITE_RESP} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     id_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic [7:0]          cnt_q;
   logic                rd_pri_q;
   logic                err_q;
   logic                pend_q;
   logic                hold_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          rresp_q;
   logic                rlast_q;

   logic                grant_rd, grant_wr;
   logic [ADDR_W-1:0]   step, incr_addr, wrap_bytes, wrap_mask, beat_next;
   logic                beat_err, last_beat;
   logic                rd_issue, rvalid_c, rlast_c, r_hs;
   logic [DATA_W-1:0]   rdata_c;
   logic [1:0]          rresp_c;
   logic [MEM_AW-1:0]   word_addr;

   // Cache/prot attributes and wlast play no part in this slave.
   logic unused_attr;
   assign unused_attr = ^{awcache_s0, awprot_s0, arcache_s0, arprot_s0, wlast_s0};

   // Grants are masked by reset so the ready outputs stay low while it is held.
   assign grant_rd = pad_cpu_rst_b && arvalid_s0 && (!awvalid_s0 || rd_pri_q);
   assign grant_wr = pad_cpu_rst_b && awvalid_s0 && (!arvalid_s0 || !rd_pri_q);

   always_comb begin
      step       = ADDR_ONE << size_q;
      incr_addr  = addr_q + step;
      wrap_bytes = ADDR_W'({1'b0, len_q} + 9'd1) << size_q;
      wrap_mask  = wrap_bytes - ADDR_ONE;
      case (burst_q)
         BURST_FIXED: beat_next = addr_q;
         BURST_WRAP:  beat_next = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     beat_next = incr_addr;
      endcase
   end

   assign beat_err  = ({1'b0, addr_q} >= MEM_BYTES) || (size_q > MAX_SIZE) ||
                      ((burst_q == BURST_WRAP) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
   assign last_beat = (cnt_q == len_q);
   assign word_addr = MEM_AW'(addr_q >> LSB);

   // pend_q marks the cycle memory data is on mem_rdata_i; hold_q replays it while stalled.
   assign rd_issue = (state_q == READ) && !pend_q && !hold_q;
   assign rvalid_c = pend_q || hold_q;
   assign rdata_c  = hold_q ? rdata_q : (beat_err ? '0 : mem_rdata_i);
   assign rresp_c  = hold_q ? rresp_q : (beat_err ? RESP_SLVERR : RESP_OKAY);
   assign rlast_c  = hold_q ? rlast_q : (pend_q && last_beat);
   assign r_hs     = (state_q == READ) && rvalid_c && rready_s0;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) state_q <= IDLE;
      else                state_q <= state_d;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      arready_s0  = 1'b0;
      awready_s0  = 1'b0;
      wready_s0   = 1'b0;
      bvalid_s0   = 1'b0;
      bid_s0      = '0;
      bresp_s0    = RESP_OKAY;
      rvalid_s0   = 1'b0;
      rid_s0      = '0;
      rdata_s0    = '0;
      rresp_s0    = RESP_OKAY;
      rlast_s0    = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_strb_o  = '0;
      case (state_q)
         IDLE: begin
            arready_s0 = grant_rd;
            awready_s0 = grant_wr;
            if (grant_rd)      state_d = READ;
            else if (grant_wr) state_d = WRITE;
         end
         READ: begin
            rid_s0 = id_q;
            if (rvalid_c) begin
               rvalid_s0 = 1'b1;
               rdata_s0  = rdata_c;
               rresp_s0  = rresp_c;
               rlast_s0  = rlast_c;
            end
            if (rd_issue && !beat_err) begin
               mem_req_o  = 1'b1;
               mem_addr_o = word_addr;
            end
            if (r_hs && rlast_c) state_d = IDLE;
         end
         WRITE: begin
            wready_s0 = 1'b1;
            if (wvalid_s0 && !beat_err) begin
               mem_req_o   = 1'b1;
               mem_we_o    = 1'b1;
               mem_addr_o  = word_addr;
               mem_wdata_o = wdata_s0;
               mem_strb_o  = wstrb_s0;
            end
            if (wvalid_s0 && last_beat) state_d = WRITE_RESP;
         end
         WRITE_RESP: begin
            bvalid_s0 = 1'b1;
            bid_s0    = id_q;
            bresp_s0  = err_q ? RESP_SLVERR : RESP_OKAY;
            if (bready_s0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         cnt_q    <= '0;
         rd_pri_q <= 1'b1;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         hold_q   <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= '0;
         rlast_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               pend_q <= 1'b0;
               hold_q <= 1'b0;
               if (grant_rd) begin
                  id_q     <= arid_s0;
                  addr_q   <= araddr_s0;
                  len_q    <= arlen_s0;
                  size_q   <= arsize_s0;
                  burst_q  <= arburst_s0;
                  rd_pri_q <= 1'b0;
               end else if (grant_wr) begin
                  id_q     <= awid_s0;
                  addr_q   <= awaddr_s0;
                  len_q    <= awlen_s0;
                  size_q   <= awsize_s0;
                  burst_q  <= awburst_s0;
                  rd_pri_q <= 1'b1;
               end
            end
            READ: begin
               pend_q <= rd_issue;
               if (pend_q && !rready_s0) begin
                  hold_q  <= 1'b1;
                  rdata_q <= rdata_c;
                  rresp_q <= rresp_c;
                  rlast_q <= rlast_c;
               end
               if (r_hs) begin
                  hold_q <= 1'b0;
                  addr_q <= beat_next;
                  cnt_q  <= rlast_c ? 8'd0 : cnt_q + 8'd1;
               end
            end
            WRITE: begin
               if (wvalid_s0) begin
                  err_q  <= err_q | beat_err;
                  addr_q <= beat_next;
                  cnt_q  <= last_beat ? 8'd0 : cnt_q + 8'd1;
               end
            end
            WRITE_RESP: begin
               if (bready_s0) err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_our_axi_slave_param.sv
// Directed bench for our_axi_slave_param: bursts, wrap, arbitration, errors, stalls, reset.
module tb_our_axi_slave_param;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 40;
   localparam int ID_W   = 8;
   localparam int MEM_AW = 21;

   logic pll_core_cpuclk = 1'b0;
   logic pad_cpu_rst_b;
   logic [ID_W-1:0] awid_s0, arid_s0, bid_s0, rid_s0;
   logic [ADDR_W-1:0] awaddr_s0, araddr_s0;
   logic [7:0] awlen_s0, arlen_s0;
   logic [2:0] awsize_s0, arsize_s0, awprot_s0, arprot_s0;
   logic [1:0] awburst_s0, arburst_s0, bresp_s0, rresp_s0;
   logic [3:0] awcache_s0, arcache_s0;
   logic awvalid_s0, awready_s0, arvalid_s0, arready_s0;
   logic [DATA_W-1:0] wdata_s0, rdata_s0, mem_wdata_o, mem_rdata_i;
   logic [DATA_W/8-1:0] wstrb_s0, mem_strb_o;
   logic wlast_s0, wvalid_s0, wready_s0, bvalid_s0, bready_s0;
   logic rlast_s0, rvalid_s0, rready_s0;
   logic mem_req_o, mem_we_o;
   logic [MEM_AW-1:0] mem_addr_o;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   our_axi_slave_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
      .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst_b(pad_cpu_rst_b),
      .awid_s0(awid_s0), .awaddr_s0(awaddr_s0), .awlen_s0(awlen_s0), .awsize_s0(awsize_s0),
      .awburst_s0(awburst_s0), .awcache_s0(awcache_s0), .awprot_s0(awprot_s0),
      .awvalid_s0(awvalid_s0), .awready_s0(awready_s0),
      .wdata_s0(wdata_s0), .wstrb_s0(wstrb_s0), .wlast_s0(wlast_s0), .wvalid_s0(wvalid_s0),
      .wready_s0(wready_s0),
      .bid_s0(bid_s0), .bresp_s0(bresp_s0), .bvalid_s0(bvalid_s0), .bready_s0(bready_s0),
      .arid_s0(arid_s0), .araddr_s0(araddr_s0), .arlen_s0(arlen_s0), .arsize_s0(arsize_s0),
      .arburst_s0(arburst_s0), .arcache_s0(arcache_s0), .arprot_s0(arprot_s0),
      .arvalid_s0(arvalid_s0), .arready_s0(arready_s0),
      .rid_s0(rid_s0), .rdata_s0(rdata_s0), .rresp_s0(rresp_s0), .rlast_s0(rlast_s0),
      .rvalid_s0(rvalid_s0), .rready_s0(rready_s0),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 pll_core_cpuclk = ~pll_core_cpuclk;

   // Read data encodes the word address; non-read cycles return filler so a stall must replay.
   function automatic logic [DATA_W-1:0] pat(input logic [MEM_AW-1:0] a);
      return {4{11'h5A5, a}};
   endfunction

   always @(posedge pll_core_cpuclk)
      mem_rdata_i <= (mem_req_o && !mem_we_o) ? pat(mem_addr_o) : {8{16'hDEAD}};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_ar(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      arid_s0 = id; araddr_s0 = addr; arlen_s0 = len; arsize_s0 = size; arburst_s0 = burst;
      arvalid_s0 = 1'b1;
   endtask

   task automatic drive_aw(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      awid_s0 = id; awaddr_s0 = addr; awlen_s0 = len; awsize_s0 = size; awburst_s0 = burst;
      awvalid_s0 = 1'b1;
   endtask

   task automatic apply_reset;
      @(negedge pll_core_cpuclk);
      pad_cpu_rst_b = 1'b0;
      arvalid_s0 = 1'b0; awvalid_s0 = 1'b0; wvalid_s0 = 1'b0; bready_s0 = 1'b0;
      repeat (2) @(negedge pll_core_cpuclk);
      pad_cpu_rst_b = 1'b1;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b1; awvalid_s0 = 1'b1;
      #1;
      chk_cnt++; if (arready_s0 !== 1'b0 || awready_s0 !== 1'b0) $display("FAIL rst_ready: ar=%0b aw=%0b want 0/0", arready_s0, awready_s0); else pass_cnt++;
      chk_cnt++; if (rvalid_s0 !== 1'b0 || bvalid_s0 !== 1'b0 || wready_s0 !== 1'b0) $display("FAIL rst_valid: r=%0b b=%0b w=%0b want 0", rvalid_s0, bvalid_s0, wready_s0); else pass_cnt++;
      chk_cnt++; if (mem_req_o !== 1'b0 || bid_s0 !== 8'h0 || rid_s0 !== 8'h0) $display("FAIL rst_mem: req=%0b bid=%h rid=%h want 0", mem_req_o, bid_s0, rid_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b0; awvalid_s0 = 1'b0;
      pad_cpu_rst_b = 1'b1;
      #1;
      chk_cnt++; if (arready_s0 !== 1'b0 || awready_s0 !== 1'b0) $display("FAIL idle_ready: ar=%0b aw=%0b want 0/0", arready_s0, awready_s0); else pass_cnt++;
   endtask

   task automatic test_incr_write;
      logic [DATA_W-1:0] exp_d;
      logic [15:0] exp_s;
      @(negedge pll_core_cpuclk);
      drive_aw(8'h5A, 40'h100, 8'd3, 3'd4, 2'b01);
      #1;
      chk_cnt++; if (awready_s0 !== 1'b1 || arready_s0 !== 1'b0) $display("FAIL incr_aw_grant: aw=%0b ar=%0b want 1/0", awready_s0, arready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      awvalid_s0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_d = {4{32'hC0DE_0000 + 32'(i)}};
         exp_s = 16'hFFFF >> i;
         wvalid_s0 = 1'b1; wdata_s0 = exp_d; wstrb_s0 = exp_s; wlast_s0 = (i == 3);
         #1;
         chk_cnt++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 21'h10 + 21'(i)) $display("FAIL incr_w_addr%0d: req=%0b we=%0b addr=%h want 1/1/%h", i, mem_req_o, mem_we_o, mem_addr_o, 21'h10 + 21'(i)); else pass_cnt++;
         chk_cnt++; if (mem_wdata_o !== exp_d || mem_strb_o !== exp_s) $display("FAIL incr_w_data%0d: data=%h strb=%h want %h/%h", i, mem_wdata_o, mem_strb_o, exp_d, exp_s); else pass_cnt++;
         @(negedge pll_core_cpuclk);
      end
      wvalid_s0 = 1'b0; wlast_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b1 || bid_s0 !== 8'h5A || bresp_s0 !== 2'b00) $display("FAIL incr_b: bvalid=%0b bid=%h bresp=%b want 1/5a/00", bvalid_s0, bid_s0, bresp_s0); else pass_cnt++;
      bready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      bready_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b0 || bid_s0 !== 8'h0) $display("FAIL incr_b_done: bvalid=%0b bid=%h want 0/00", bvalid_s0, bid_s0); else pass_cnt++;
   endtask

   task automatic test_wrap_read;
      logic [MEM_AW-1:0] exp_a [4];
      exp_a = '{21'h13, 21'h10, 21'h11, 21'h12};
      @(negedge pll_core_cpuclk);
      drive_ar(8'h33, 40'h130, 8'd3, 3'd4, 2'b10);
      rready_s0 = 1'b1;
      #1;
      chk_cnt++; if (arready_s0 !== 1'b1) $display("FAIL wrap_ar_grant: ar=%0b want 1", arready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_cnt++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== exp_a[i] || rvalid_s0 !== 1'b0) $display("FAIL wrap_req%0d: req=%0b we=%0b addr=%h rvalid=%0b want 1/0/%h/0", i, mem_req_o, mem_we_o, mem_addr_o, rvalid_s0, exp_a[i]); else pass_cnt++;
         @(negedge pll_core_cpuclk);
         #1;
         chk_cnt++; if (rvalid_s0 !== 1'b1 || rdata_s0 !== pat(exp_a[i]) || rresp_s0 !== 2'b00 || rid_s0 !== 8'h33) $display("FAIL wrap_beat%0d: rvalid=%0b data=%h resp=%b rid=%h want 1/%h/00/33", i, rvalid_s0, rdata_s0, rresp_s0, rid_s0, pat(exp_a[i])); else pass_cnt++;
         chk_cnt++; if (rlast_s0 !== (i == 3)) $display("FAIL wrap_rlast%0d: got %0b want %0b", i, rlast_s0, (i == 3)); else pass_cnt++;
         @(negedge pll_core_cpuclk);
      end
      #1;
      chk_cnt++; if (rvalid_s0 !== 1'b0 || rid_s0 !== 8'h0) $display("FAIL wrap_done: rvalid=%0b rid=%h want 0/00", rvalid_s0, rid_s0); else pass_cnt++;
   endtask

   task automatic test_arbitration;
      apply_reset();
      @(negedge pll_core_cpuclk);
      drive_ar(8'h01, 40'h200, 8'd0, 3'd4, 2'b01);
      drive_aw(8'h02, 40'h300, 8'd0, 3'd4, 2'b01);
      rready_s0 = 1'b1;
      #1;
      chk_cnt++; if (arready_s0 !== 1'b1 || awready_s0 !== 1'b0) $display("FAIL arb_first: ar=%0b aw=%0b want 1/0", arready_s0, awready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      #1;
      chk_cnt++; if (arready_s0 !== 1'b0 || awready_s0 !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 21'h20) $display("FAIL arb_busy: ar=%0b aw=%0b req=%0b addr=%h want 0/0/1/20", arready_s0, awready_s0, mem_req_o, mem_addr_o); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      #1;
      chk_cnt++; if (rvalid_s0 !== 1'b1 || rlast_s0 !== 1'b1 || rid_s0 !== 8'h01 || rdata_s0 !== pat(21'h20)) $display("FAIL arb_rbeat: rvalid=%0b rlast=%0b rid=%h data=%h", rvalid_s0, rlast_s0, rid_s0, rdata_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      #1;
      chk_cnt++; if (awready_s0 !== 1'b1 || arready_s0 !== 1'b0) $display("FAIL arb_second: ar=%0b aw=%0b want 0/1", arready_s0, awready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b0; awvalid_s0 = 1'b0;
      wvalid_s0 = 1'b1; wdata_s0 = {4{32'h1234_5678}}; wstrb_s0 = 16'hFFFF; wlast_s0 = 1'b1;
      #1;
      chk_cnt++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 21'h30) $display("FAIL arb_wbeat: req=%0b we=%0b addr=%h want 1/1/30", mem_req_o, mem_we_o, mem_addr_o); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      wvalid_s0 = 1'b0; wlast_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b1 || bid_s0 !== 8'h02 || bresp_s0 !== 2'b00) $display("FAIL arb_b: bvalid=%0b bid=%h bresp=%b want 1/02/00", bvalid_s0, bid_s0, bresp_s0); else pass_cnt++;
      bready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      bready_s0 = 1'b0;
   endtask

   task automatic test_write_error;
      @(negedge pll_core_cpuclk);
      drive_aw(8'h0E, 40'h200_0000, 8'd1, 3'd4, 2'b01);
      #1;
      chk_cnt++; if (awready_s0 !== 1'b1) $display("FAIL err_aw_grant: aw=%0b want 1", awready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      awvalid_s0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wvalid_s0 = 1'b1; wdata_s0 = {8{16'hBAD0}}; wstrb_s0 = 16'hFFFF; wlast_s0 = (i == 1);
         #1;
         chk_cnt++; if (mem_req_o !== 1'b0 || wready_s0 !== 1'b1) $display("FAIL err_w%0d: req=%0b wready=%0b want 0/1", i, mem_req_o, wready_s0); else pass_cnt++;
         @(negedge pll_core_cpuclk);
      end
      wvalid_s0 = 1'b0; wlast_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b1 || bresp_s0 !== 2'b10 || bid_s0 !== 8'h0E) $display("FAIL err_b: bvalid=%0b bresp=%b bid=%h want 1/10/0e", bvalid_s0, bresp_s0, bid_s0); else pass_cnt++;
      bready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      bready_s0 = 1'b0;
      drive_aw(8'h07, 40'h40, 8'd0, 3'd4, 2'b01);
      @(negedge pll_core_cpuclk);
      awvalid_s0 = 1'b0;
      wvalid_s0 = 1'b1; wdata_s0 = {4{32'hFACE_0001}}; wstrb_s0 = 16'h00FF; wlast_s0 = 1'b1;
      #1;
      chk_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 21'h4) $display("FAIL err_clear_w: req=%0b addr=%h want 1/04", mem_req_o, mem_addr_o); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      wvalid_s0 = 1'b0; wlast_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b1 || bresp_s0 !== 2'b00) $display("FAIL err_clear_b: bvalid=%0b bresp=%b want 1/00", bvalid_s0, bresp_s0); else pass_cnt++;
      bready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      bready_s0 = 1'b0;
   endtask

   task automatic test_read_stall;
      @(negedge pll_core_cpuclk);
      drive_ar(8'h44, 40'h400, 8'd3, 3'd4, 2'b01);
      rready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 21'h40 + 21'(i)) $display("FAIL stall_req%0d: req=%0b addr=%h want 1/%h", i, mem_req_o, mem_addr_o, 21'h40 + 21'(i)); else pass_cnt++;
         @(negedge pll_core_cpuclk);
         if (i == 1) rready_s0 = 1'b0;
         #1;
         chk_cnt++; if (rvalid_s0 !== 1'b1 || rdata_s0 !== pat(21'h40 + 21'(i)) || rlast_s0 !== (i == 3)) $display("FAIL stall_beat%0d: rvalid=%0b data=%h rlast=%0b", i, rvalid_s0, rdata_s0, rlast_s0); else pass_cnt++;
         if (i == 1) begin
            for (int s = 0; s < 4; s++) begin
               @(negedge pll_core_cpuclk);
               #1;
               chk_cnt++; if (rvalid_s0 !== 1'b1 || rdata_s0 !== pat(21'h41) || rlast_s0 !== 1'b0 || mem_req_o !== 1'b0) $display("FAIL stall_hold%0d: rvalid=%0b data=%h rlast=%0b req=%0b", s, rvalid_s0, rdata_s0, rlast_s0, mem_req_o); else pass_cnt++;
            end
            rready_s0 = 1'b1;
         end
         @(negedge pll_core_cpuclk);
      end
      #1;
      chk_cnt++; if (rvalid_s0 !== 1'b0) $display("FAIL stall_done: rvalid=%0b want 0", rvalid_s0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_burst;
      @(negedge pll_core_cpuclk);
      drive_ar(8'h77, 40'h800, 8'd7, 3'd4, 2'b01);
      rready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b0;
      repeat (5) @(negedge pll_core_cpuclk);
      #1;
      chk_cnt++; if (rvalid_s0 !== 1'b1 || rdata_s0 !== pat(21'h82)) $display("FAIL rstmid_beat2: rvalid=%0b data=%h want 1/%h", rvalid_s0, rdata_s0, pat(21'h82)); else pass_cnt++;
      pad_cpu_rst_b = 1'b0;
      #1;
      chk_cnt++; if (rvalid_s0 !== 1'b0 || mem_req_o !== 1'b0 || rid_s0 !== 8'h0) $display("FAIL rstmid_async: rvalid=%0b req=%0b rid=%h want 0", rvalid_s0, mem_req_o, rid_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      pad_cpu_rst_b = 1'b1;
      #1;
      chk_cnt++; if (rvalid_s0 !== 1'b0 || rid_s0 !== 8'h0) $display("FAIL rstmid_after: rvalid=%0b rid=%h want 0/00", rvalid_s0, rid_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      drive_ar(8'h78, 40'h900, 8'd1, 3'd4, 2'b01);
      awvalid_s0 = 1'b1;
      #1;
      chk_cnt++; if (arready_s0 !== 1'b1 || awready_s0 !== 1'b0) $display("FAIL rstmid_idle: ar=%0b aw=%0b want 1/0", arready_s0, awready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      arvalid_s0 = 1'b0; awvalid_s0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 21'h90 + 21'(i)) $display("FAIL rstmid_req%0d: req=%0b addr=%h want 1/%h", i, mem_req_o, mem_addr_o, 21'h90 + 21'(i)); else pass_cnt++;
         @(negedge pll_core_cpuclk);
         #1;
         chk_cnt++; if (rvalid_s0 !== 1'b1 || rdata_s0 !== pat(21'h90 + 21'(i)) || rlast_s0 !== (i == 1) || rid_s0 !== 8'h78) $display("FAIL rstmid_beat%0d: rvalid=%0b data=%h rlast=%0b rid=%h", i, rvalid_s0, rdata_s0, rlast_s0, rid_s0); else pass_cnt++;
         @(negedge pll_core_cpuclk);
      end
   endtask

   task automatic test_long_burst;
      @(negedge pll_core_cpuclk);
      drive_aw(8'h99, 40'h1000, 8'd255, 3'd4, 2'b00);
      #1;
      chk_cnt++; if (awready_s0 !== 1'b1) $display("FAIL long_aw_grant: aw=%0b want 1", awready_s0); else pass_cnt++;
      @(negedge pll_core_cpuclk);
      awvalid_s0 = 1'b0;
      for (int i = 0; i < 256; i++) begin
         wvalid_s0 = 1'b1; wdata_s0 = {16{8'(i)}}; wstrb_s0 = 16'hFFFF; wlast_s0 = (i == 255);
         #1;
         chk_cnt++; if (mem_req_o !== 1'b1 || mem_addr_o !== 21'h100 || bvalid_s0 !== 1'b0) $display("FAIL long_beat%0d: req=%0b addr=%h bvalid=%0b want 1/100/0", i, mem_req_o, mem_addr_o, bvalid_s0); else pass_cnt++;
         @(negedge pll_core_cpuclk);
      end
      wvalid_s0 = 1'b0; wlast_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b1 || bresp_s0 !== 2'b00 || bid_s0 !== 8'h99) $display("FAIL long_b: bvalid=%0b bresp=%b bid=%h want 1/00/99", bvalid_s0, bresp_s0, bid_s0); else pass_cnt++;
      bready_s0 = 1'b1;
      @(negedge pll_core_cpuclk);
      bready_s0 = 1'b0;
      #1;
      chk_cnt++; if (bvalid_s0 !== 1'b0) $display("FAIL long_b_done: bvalid=%0b want 0", bvalid_s0); else pass_cnt++;
   endtask

   initial begin
      pad_cpu_rst_b = 1'b0;
      awid_s0 = '0; awaddr_s0 = '0; awlen_s0 = '0; awsize_s0 = '0; awburst_s0 = '0;
      awcache_s0 = '0; awprot_s0 = '0; awvalid_s0 = 1'b0;
      arid_s0 = '0; araddr_s0 = '0; arlen_s0 = '0; arsize_s0 = '0; arburst_s0 = '0;
      arcache_s0 = '0; arprot_s0 = '0; arvalid_s0 = 1'b0;
      wdata_s0 = '0; wstrb_s0 = '0; wlast_s0 = 1'b0; wvalid_s0 = 1'b0;
      bready_s0 = 1'b0; rready_s0 = 1'b0;
      test_reset();
      test_incr_write();
      test_wrap_read();
      test_arbitration();
      test_write_error();
      test_read_stall();
      test_reset_mid_burst();
      test_long_burst();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
